// File: rtl/index_decoder_if.sv
// Handshake bundle for index_decoder: code beats in, accumulated mask frames out.
// The slave modport is the decoder's view; master is the upstream/downstream side.
interface index_decoder_if;
    logic [2:0] code;
    logic       code_valid;
    logic       code_last;
    logic       code_ready;
    logic [7:0] mask;
    logic       mask_valid;
    logic       mask_ready;
    logic [3:0] beats;
    logic       dup;

    modport slave (
        input  code, code_valid, code_last, mask_ready,
        output code_ready, mask, mask_valid, beats, dup
    );

    modport master (
        output code, code_valid, code_last, mask_ready,
        input  code_ready, mask, mask_valid, beats, dup
    );
endinterface

// File: rtl/index_decoder.sv
// Accumulates index codes into a one-hot mask per frame, then holds the frame until
// downstream takes it. Frames close on code_last, MAX_BEATS beats, or a full mask.
module index_decoder #(
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic          clk,
    input  logic          rst,
    index_decoder_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] mask_q, mask_nxt;
    logic [3:0] beats_q, beats_nxt;
    logic       dup_q, dup_nxt;
    logic [7:0] onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            mask_q  <= '0;
            beats_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mask_q  <= mask_nxt;
            beats_q <= beats_nxt;
            dup_q   <= dup_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        beats_nxt = beats_q;
        dup_nxt   = dup_q;
        onehot    = 8'(1) << bus.code;
        unique case (state)
            ACCUM: begin
                if (bus.code_valid) begin
                    mask_nxt  = mask_q | onehot;
                    beats_nxt = beats_q + 4'd1;
                    dup_nxt   = dup_q | ((mask_q & onehot) != '0);
                    if (bus.code_last || beats_nxt == 4'(MAX_BEATS) || mask_nxt == '1)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Release edge only clears; the next frame's first beat waits a cycle.
                if (bus.mask_ready) begin
                    state_nxt = ACCUM;
                    mask_nxt  = '0;
                    beats_nxt = '0;
                    dup_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign bus.code_ready = (state == ACCUM);
    assign bus.mask_valid = (state == HOLD);
    assign bus.mask       = mask_q;
    assign bus.beats      = beats_q;
    assign bus.dup        = dup_q;
endmodule

// File: doc/index_decoder.md
INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 Parameter MAX_BEATS, default 8, SHALL be the maximum beats accepted per frame before forced close (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 code  input  3  index value (0..7) of one set bit.
REQ-005 code_valid  input  1  code beat present.
REQ-006 code_last  input  1  beat closes the current frame; qualified by code_valid.
REQ-007 code_ready  output  1  block can accept a code beat this cycle.
REQ-008 mask  output  8  accumulated vector, bit k set if index k was received in the frame.
REQ-009 mask_valid  output  1  mask holds a completed frame.
REQ-010 mask_ready  input  1  downstream accepts mask this cycle.
REQ-011 beats  output  4  number of beats accepted in the current or held frame.
REQ-012 dup  output  1  at least one code in the frame repeated an already-set index.

Function
REQ-013 Block SHALL implement two states, ACCUM and HOLD; reset state is ACCUM.
REQ-014 code_ready SHALL equal 1 in ACCUM and 0 in HOLD, driven from registered state only; no combinational path from any input.
REQ-015 Beat accepted SHALL mean code_valid=1 and code_ready=1 on a rising edge.
REQ-016 On an accepted beat, the block SHALL set mask bit code on that edge (mask |= one-hot(code)) and increment beats by 1.
REQ-017 On an accepted beat where mask bit code is already 1, dup SHALL be set to 1 on that edge; dup stays set until the frame is cleared.
REQ-018 ACCUM->HOLD SHALL occur on the edge of an accepted beat that has code_last=1, or makes beats equal MAX_BEATS, or makes mask equal 8'hFF; the first condition met ends the frame.
REQ-019 mask_valid SHALL equal 1 exactly in HOLD; it rises on the same edge as the closing beat is written (latency 0 cycles from closing-beat edge to visible mask).
REQ-020 In HOLD, mask, beats and dup SHALL stay constant regardless of code_valid, code or code_last.
REQ-021 HOLD->ACCUM SHALL occur on an edge with mask_ready=1; on that edge mask, beats and dup SHALL clear to 0.
REQ-022 The block SHALL accept no beat on the HOLD->ACCUM edge; the first beat of the next frame is accepted the following cycle at the earliest.
REQ-023 mask_ready while in ACCUM SHALL have no effect.
REQ-024 code_last with code_valid=0 SHALL be ignored.
REQ-025 beats SHALL never exceed MAX_BEATS; no wrap-around occurs.
REQ-026 A frame closing with a duplicate beat SHALL present dup=1 together with mask_valid=1.

Reset
REQ-027 On rst=1 at a rising edge, the block SHALL enter ACCUM and set mask=0, beats=0, dup=0, mask_valid=0, code_ready=1.
REQ-028 rst SHALL take priority over every simultaneous beat, close or mask_ready event, including in HOLD or mid-frame; the partial frame is discarded.
REQ-029 code_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-030 Codes 0,3,7 with last on 7 -> mask=8'h89, beats=3, dup=0, mask_valid=1 on the edge accepting 7; code_ready=0 next cycle.
REQ-031 Codes 2,2,5(last) -> mask=8'h24, beats=3, dup=1; mask_ready=1 one cycle later -> mask=0, beats=0, dup=0, code_ready=1.
REQ-032 MAX_BEATS=8, eight beats code=1, none with last -> HOLD after 8th beat, mask=8'h02, beats=8, dup=1.
REQ-033 Codes 0..7 in order, no last, MAX_BEATS=15 -> close on 8th beat via mask=8'hFF, beats=8.
REQ-034 In HOLD with mask_ready=0, drive code_valid=1 for 5 cycles -> mask, beats unchanged, code_ready=0 throughout; then mask_ready=1 and code_valid=1 -> no beat on release edge, beat accepted next cycle.
REQ-035 Two beats accepted, then rst=1 together with a code_valid=1/code_last=1 beat -> mask=0, beats=0, mask_valid=0, ACCUM.
